// File: rtl/shaft_model.sv
// Behavioural plant for the freight-lift cabin and shaft.
// Turns the cabin controller's motor command into cabin motion on a step counter,
// and returns the limit-switch endstops the controller expects.
//
// Ports
//   clk      in   1  system clock
//   rst      in   1  synchronous reset, active-high
//   motor    in   2  command: 00 stop, 01 up, 10 down, 11 illegal
//   endstop  out  3  {Fc3,Fc2,Fc1}, one-hot when the cabin is exactly at a floor, else 000
//   floor    out  2  last floor reached (1..3)
//   moving   out  1  cabin is travelling up or down
//   fault    out  1  sticky overrun / illegal-command flag, cleared only by rst
module shaft_model #(
    parameter int unsigned TICKS_PER_STEP = 50000,
    parameter int unsigned FLOOR_SPAN     = 20,
    parameter int unsigned START_FLOOR    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] motor,
    output logic [2:0] endstop,
    output logic [1:0] floor,
    output logic       moving,
    output logic       fault
);

    localparam int unsigned TOP = 2 * FLOOR_SPAN;
    localparam int unsigned PW  = $clog2(TOP + 1);
    localparam int unsigned TW  = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [PW-1:0] POS_F1    = '0;
    localparam logic [PW-1:0] POS_F2    = PW'(FLOOR_SPAN);
    localparam logic [PW-1:0] POS_F3    = PW'(TOP);
    localparam logic [PW-1:0] POS_START = PW'((START_FLOOR - 1) * FLOOR_SPAN);
    localparam logic [TW-1:0] TIMER_TC  = TW'(TICKS_PER_STEP - 1);

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b01;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    floor_q, floor_d;
    logic          fault_q;
    state_t        req_state;

    // State register: reset snaps the cabin to the start floor, even mid-travel
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            pos_q   <= POS_START;
            timer_q <= '0;
            floor_q <= 2'(START_FLOOR);
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            timer_q <= timer_d;
            floor_q <= floor_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    // Decode the motor command into the state it asks for
    always_comb begin
        req_state = ST_STOP;
        unique case (motor)
            MOTOR_STOP: req_state = ST_STOP;
            MOTOR_UP:   req_state = ST_UP;
            MOTOR_DOWN: req_state = ST_DOWN;
            default:    req_state = ST_FAULT;
        endcase
    end

    // Next state, step timer and cabin position
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        timer_d = '0;
        floor_d = floor_q;

        if (state_q != ST_FAULT) begin
            state_d = req_state;
            // Timer only runs while the same travel direction is held;
            // any state change discards partial progress.
            if ((req_state == state_q) && (state_q == ST_UP || state_q == ST_DOWN)) begin
                if (timer_q == TIMER_TC) begin
                    timer_d = '0;
                    if (state_q == ST_UP) begin
                        // Driving into the top limit after the grace period is an overrun
                        if (pos_q == POS_F3) begin
                            state_d = ST_FAULT;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end else begin
                        if (pos_q == POS_F1) begin
                            state_d = ST_FAULT;
                        end else begin
                            pos_d = pos_q - PW'(1);
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        end

        // Floor register follows the cabin on the edge it lands on a floor
        if (pos_d == POS_F1) begin
            floor_d = 2'd1;
        end else if (pos_d == POS_F2) begin
            floor_d = 2'd2;
        end else if (pos_d == POS_F3) begin
            floor_d = 2'd3;
        end
    end

    // Endstops and moving are decodes of registered state, no added latency
    assign endstop = {pos_q == POS_F3, pos_q == POS_F2, pos_q == POS_F1};
    assign moving  = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign floor   = floor_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_shaft_model.sv
// Directed bench for shaft_model with TICKS_PER_STEP=4, FLOOR_SPAN=3, START_FLOOR=1.
// Floor positions: F1=0, F2=3, F3=6. Outputs are sampled 1 time unit after each posedge.
module tb_shaft_model;

    logic       clk;
    logic       rst;
    logic [1:0] motor;
    logic [2:0] endstop;
    logic [1:0] floor;
    logic       moving;
    logic       fault;

    int n_checks;
    int n_pass;

    shaft_model #(
        .TICKS_PER_STEP(4),
        .FLOOR_SPAN    (3),
        .START_FLOOR   (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .motor  (motor),
        .endstop(endstop),
        .floor  (floor),
        .moving (moving),
        .fault  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        motor = 2'b00;
        tick(2);
        rst = 1'b0;
        n_checks++; if (endstop !== 3'b001) $display("FAIL reset_endstop: got %b expected 001", endstop); else n_pass++;
        n_checks++; if (floor !== 2'd1) $display("FAIL reset_floor: got %0d expected 1", floor); else n_pass++;
        n_checks++; if (moving !== 1'b0) $display("FAIL reset_moving: got %b expected 0", moving); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else n_pass++;
    endtask

    // Floor 1 -> floor 3 with motor=01 held, then stop
    task automatic test_travel_up();
        motor = 2'b01;
        for (int e = 1; e <= 25; e++) begin
            tick(1);
            case (e)
                1: begin
                    n_checks++; if (moving !== 1'b1) $display("FAIL up_moving_e1: got %b expected 1", moving); else n_pass++;
                end
                4: begin
                    n_checks++; if (endstop !== 3'b001) $display("FAIL up_endstop_e4: got %b expected 001", endstop); else n_pass++;
                end
                5: begin
                    n_checks++; if (endstop !== 3'b000) $display("FAIL up_endstop_e5: got %b expected 000", endstop); else n_pass++;
                    n_checks++; if (floor !== 2'd1) $display("FAIL up_floor_e5: got %0d expected 1", floor); else n_pass++;
                end
                12: begin
                    n_checks++; if (endstop !== 3'b000) $display("FAIL up_endstop_e12: got %b expected 000", endstop); else n_pass++;
                end
                13: begin
                    n_checks++; if (endstop !== 3'b010) $display("FAIL up_endstop_e13: got %b expected 010", endstop); else n_pass++;
                    n_checks++; if (floor !== 2'd2) $display("FAIL up_floor_e13: got %0d expected 2", floor); else n_pass++;
                end
                24: begin
                    n_checks++; if (floor !== 2'd2) $display("FAIL up_floor_e24: got %0d expected 2", floor); else n_pass++;
                end
                25: begin
                    n_checks++; if (endstop !== 3'b100) $display("FAIL up_endstop_e25: got %b expected 100", endstop); else n_pass++;
                    n_checks++; if (floor !== 2'd3) $display("FAIL up_floor_e25: got %0d expected 3", floor); else n_pass++;
                end
                default: ;
            endcase
        end
        motor = 2'b00;
        tick(1);
        n_checks++; if (moving !== 1'b0) $display("FAIL up_stop_moving: got %b expected 0", moving); else n_pass++;
        n_checks++; if (endstop !== 3'b100) $display("FAIL up_stop_endstop: got %b expected 100", endstop); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL up_stop_fault: got %b expected 0", fault); else n_pass++;
    endtask

    // At floor 3, keep commanding up: grace period, then overrun fault
    task automatic test_limit_overrun();
        motor = 2'b01;
        tick(4);
        n_checks++; if (fault !== 1'b0) $display("FAIL overrun_grace_fault: got %b expected 0", fault); else n_pass++;
        n_checks++; if (endstop !== 3'b100) $display("FAIL overrun_grace_endstop: got %b expected 100", endstop); else n_pass++;
        tick(1);
        n_checks++; if (fault !== 1'b1) $display("FAIL overrun_fault: got %b expected 1", fault); else n_pass++;
        n_checks++; if (moving !== 1'b0) $display("FAIL overrun_moving: got %b expected 0", moving); else n_pass++;
        n_checks++; if (endstop !== 3'b100) $display("FAIL overrun_endstop: got %b expected 100", endstop); else n_pass++;
        motor = 2'b10;
        tick(8);
        n_checks++; if (endstop !== 3'b100) $display("FAIL fault_absorb_endstop: got %b expected 100", endstop); else n_pass++;
        n_checks++; if (floor !== 2'd3) $display("FAIL fault_absorb_floor: got %0d expected 3", floor); else n_pass++;
        n_checks++; if (fault !== 1'b1) $display("FAIL fault_absorb_fault: got %b expected 1", fault); else n_pass++;
        rst = 1'b1;
        motor = 2'b00;
        tick(1);
        rst = 1'b0;
        n_checks++; if (fault !== 1'b0) $display("FAIL fault_rst_fault: got %b expected 0", fault); else n_pass++;
        n_checks++; if (endstop !== 3'b001) $display("FAIL fault_rst_endstop: got %b expected 001", endstop); else n_pass++;
    endtask

    // Stop mid-segment going down from floor 2, then resume up: partial progress lost
    task automatic test_stop_mid_segment();
        motor = 2'b01;
        tick(13);
        n_checks++; if (floor !== 2'd2) $display("FAIL mid_reach_f2: got %0d expected 2", floor); else n_pass++;
        motor = 2'b00;
        tick(1);
        motor = 2'b10;
        tick(6);
        motor = 2'b00;
        tick(1);
        n_checks++; if (endstop !== 3'b000) $display("FAIL mid_stop_endstop: got %b expected 000", endstop); else n_pass++;
        n_checks++; if (floor !== 2'd2) $display("FAIL mid_stop_floor: got %0d expected 2", floor); else n_pass++;
        n_checks++; if (moving !== 1'b0) $display("FAIL mid_stop_moving: got %b expected 0", moving); else n_pass++;
        motor = 2'b01;
        tick(4);
        n_checks++; if (endstop !== 3'b000) $display("FAIL mid_resume_e4: got %b expected 000", endstop); else n_pass++;
        tick(1);
        n_checks++; if (endstop !== 3'b010) $display("FAIL mid_resume_e5: got %b expected 010", endstop); else n_pass++;
        motor = 2'b00;
        tick(1);
    endtask

    // Illegal command while moving from floor 2
    task automatic test_illegal_cmd();
        motor = 2'b01;
        tick(2);
        n_checks++; if (moving !== 1'b1) $display("FAIL illegal_pre_moving: got %b expected 1", moving); else n_pass++;
        motor = 2'b11;
        tick(1);
        n_checks++; if (fault !== 1'b1) $display("FAIL illegal_fault: got %b expected 1", fault); else n_pass++;
        n_checks++; if (moving !== 1'b0) $display("FAIL illegal_moving: got %b expected 0", moving); else n_pass++;
        n_checks++; if (endstop !== 3'b010) $display("FAIL illegal_endstop: got %b expected 010", endstop); else n_pass++;
        motor = 2'b01;
        tick(6);
        n_checks++; if (endstop !== 3'b010) $display("FAIL illegal_frozen: got %b expected 010", endstop); else n_pass++;
        rst = 1'b1;
        motor = 2'b00;
        tick(1);
        rst = 1'b0;
        n_checks++; if (floor !== 2'd1) $display("FAIL illegal_rst_floor: got %0d expected 1", floor); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL illegal_rst_fault: got %b expected 0", fault); else n_pass++;
    endtask

    // Reset between floors 2 and 3 while the up command is still asserted
    task automatic test_reset_mid_segment();
        motor = 2'b01;
        tick(18);
        n_checks++; if (endstop !== 3'b000) $display("FAIL rstmid_pre_endstop: got %b expected 000", endstop); else n_pass++;
        n_checks++; if (floor !== 2'd2) $display("FAIL rstmid_pre_floor: got %0d expected 2", floor); else n_pass++;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++; if (endstop !== 3'b001) $display("FAIL rstmid_endstop: got %b expected 001", endstop); else n_pass++;
        n_checks++; if (floor !== 2'd1) $display("FAIL rstmid_floor: got %0d expected 1", floor); else n_pass++;
        n_checks++; if (moving !== 1'b0) $display("FAIL rstmid_moving: got %b expected 0", moving); else n_pass++;
        tick(4);
        n_checks++; if (endstop !== 3'b001) $display("FAIL rstmid_restart_e4: got %b expected 001", endstop); else n_pass++;
        tick(1);
        n_checks++; if (endstop !== 3'b000) $display("FAIL rstmid_restart_e5: got %b expected 000", endstop); else n_pass++;
    endtask

    // Reverse to down right after a step, then overrun the bottom limit
    task automatic test_reversal_and_bottom();
        motor = 2'b10;
        tick(4);
        n_checks++; if (endstop !== 3'b000) $display("FAIL rev_e4: got %b expected 000", endstop); else n_pass++;
        tick(1);
        n_checks++; if (endstop !== 3'b001) $display("FAIL rev_e5_endstop: got %b expected 001", endstop); else n_pass++;
        n_checks++; if (floor !== 2'd1) $display("FAIL rev_e5_floor: got %0d expected 1", floor); else n_pass++;
        motor = 2'b00;
        tick(1);
        motor = 2'b10;
        tick(4);
        n_checks++; if (fault !== 1'b0) $display("FAIL bottom_grace_fault: got %b expected 0", fault); else n_pass++;
        tick(1);
        n_checks++; if (fault !== 1'b1) $display("FAIL bottom_fault: got %b expected 1", fault); else n_pass++;
        n_checks++; if (endstop !== 3'b001) $display("FAIL bottom_endstop: got %b expected 001", endstop); else n_pass++;
        rst = 1'b1;
        motor = 2'b00;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        motor    = 2'b00;
        #2;
        test_reset();
        test_travel_up();
        test_limit_overrun();
        test_stop_mid_segment();
        test_illegal_cmd();
        test_reset_mid_segment();
        test_reversal_and_bottom();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
